// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: instruction word -> ALU control, immediate, register addresses, op class.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: flag unsupported encodings instead of decoding them as NOP.
module rv_decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [9:0]      out_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic            out_imm_en,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [2:0]      out_class,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JAL    = 3'd4;
  localparam logic [2:0] CLS_JALR   = 3'd5;
  localparam logic [2:0] CLS_LUI    = 3'd6;
  localparam logic [2:0] CLS_AUIPC  = 3'd7;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  logic        legal;
  logic [9:0]  d_ctrl;
  logic [31:0] d_imm;
  logic        d_imm_en;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_rd_we;
  logic [2:0]  d_class;
  logic [2:0]  d_funct3;
  logic        d_illegal;

  always_comb begin
    legal     = 1'b1;
    d_ctrl    = '0;
    d_imm     = '0;
    d_imm_en  = 1'b0;
    d_rs1     = in_inst[19:15];
    d_rs2     = in_inst[24:20];
    d_rd      = in_inst[11:7];
    d_rd_we   = 1'b0;
    d_class   = CLS_ALU;
    d_funct3  = f3;
    d_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_ctrl  = {f7, f3};
        d_rd_we = 1'b1;
        legal   = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        d_imm_en = 1'b1;
        d_rd_we  = 1'b1;
        // Shifts carry funct7 through; other ops zero it so bit 30 of the immediate cannot alias SUB/SRA.
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          d_ctrl = {f7, f3};
          d_imm  = {27'b0, in_inst[24:20]};
          legal  = (f7 == F7_ZERO) || ((f3 == 3'b101) && (f7 == F7_ALT));
        end else begin
          d_ctrl = {7'b0, f3};
          d_imm  = imm_i;
        end
      end
      OPC_LOAD: begin
        d_class  = CLS_LOAD;
        d_imm_en = 1'b1;
        d_imm    = imm_i;
        d_rd_we  = 1'b1;
        legal    = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        d_class  = CLS_STORE;
        d_imm_en = 1'b1;
        d_imm    = imm_s;
        legal    = !f3[2] && (f3 != 3'b011);
      end
      OPC_BRANCH: begin
        d_class = CLS_BRANCH;
        d_imm   = imm_b;
        case (f3[2:1])
          2'b00:   d_ctrl = 10'b0100000000;
          2'b10:   d_ctrl = 10'b0000000010;
          2'b11:   d_ctrl = 10'b0000000011;
          default: legal  = 1'b0;
        endcase
      end
      OPC_JAL: begin
        d_class = CLS_JAL;
        d_imm   = imm_j;
        d_rd_we = 1'b1;
      end
      OPC_JALR: begin
        d_class  = CLS_JALR;
        d_imm_en = 1'b1;
        d_imm    = imm_i;
        d_rd_we  = 1'b1;
        legal    = (f3 == 3'b000);
      end
      OPC_LUI: begin
        d_class  = CLS_LUI;
        d_rs1    = 5'd0;
        d_imm_en = 1'b1;
        d_imm    = imm_u;
        d_rd_we  = 1'b1;
      end
      OPC_AUIPC: begin
        d_class  = CLS_AUIPC;
        d_imm_en = 1'b1;
        d_imm    = imm_u;
        d_rd_we  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      d_illegal = 1'b1;
      d_rd_we   = 1'b0;
      d_class   = CLS_ALU;
      d_ctrl    = '0;
      d_imm     = '0;
      d_imm_en  = 1'b0;
`else
      d_ctrl    = '0;
      d_imm     = '0;
      d_imm_en  = 1'b0;
      d_rd_we   = 1'b0;
      d_class   = CLS_ALU;
      d_rs1     = 5'd0;
      d_rs2     = 5'd0;
      d_rd      = 5'd0;
      d_funct3  = 3'd0;
`endif
    end
    if (d_rd == 5'd0) d_rd_we = 1'b0;
  end

  // Handshake: a beat moves on a side when its valid and ready are both high at the rising edge;
  // a held output stays stable until out_ready, and flush drops both the held and the offered beat.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      out_ctrl    <= '0;
      out_imm     <= '0;
      out_imm_en  <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_class   <= '0;
      out_funct3  <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_ctrl    <= d_ctrl;
      out_imm     <= d_imm;
      out_imm_en  <= d_imm_en;
      out_rs1     <= d_rs1;
      out_rs2     <= d_rs2;
      out_rd      <= d_rd;
      out_rd_we   <= d_rd_we;
      out_class   <= d_class;
      out_funct3  <= d_funct3;
      out_illegal <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed test-plan vectors followed by randomized traffic.
module tb_rv_decode_stage;

  localparam int          W        = 98;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [9:0]  out_ctrl;
  logic        out_imm_en, out_rd_we, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_class, out_funct3;

  logic [W-1:0] exp_q[$];
  int           n_total = 0;
  int           n_pass  = 0;
  logic         mon_en  = 1'b0;

  rv_decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_imm_en(out_imm_en),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_class(out_class), .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: field values straight from the RV32I encoding rules.
  function automatic logic [W-1:0] model(input logic [31:0] inst, input logic [31:0] pc);
    logic [6:0]  opc, f7;
    logic [2:0]  f3, cls;
    logic [9:0]  ctrl;
    logic [31:0] imm, i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ie, we, ok, ill;
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    rs1 = inst[19:15]; rs2 = inst[24:20]; rd = inst[11:7];
    i_imm = 32'($signed(inst[31:20]));
    s_imm = 32'($signed({inst[31:25], inst[11:7]}));
    b_imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    u_imm = inst & 32'hFFFF_F000;
    j_imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    ctrl = '0; imm = '0; ie = 1'b0; we = 1'b0; ok = 1'b1; cls = 3'd0; ill = 1'b0;
    case (opc)
      7'h33: begin
        we = 1'b1; ctrl = {f7, f3};
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        ie = 1'b1; we = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ctrl = {f7, f3}; imm = 32'(inst[24:20]);
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        end else begin
          ctrl = 10'(f3); imm = i_imm;
        end
      end
      7'h03: begin cls = 3'd1; ie = 1'b1; we = 1'b1; imm = i_imm; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      7'h23: begin cls = 3'd2; ie = 1'b1; imm = s_imm; ok = f3 inside {3'd0, 3'd1, 3'd2}; end
      7'h63: begin
        cls = 3'd3; imm = b_imm; ok = !(f3 inside {3'd2, 3'd3});
        if (f3 < 3'd2) ctrl = 10'h100;
        else if (f3 inside {3'd4, 3'd5}) ctrl = 10'd2;
        else ctrl = 10'd3;
      end
      7'h6f: begin cls = 3'd4; we = 1'b1; imm = j_imm; end
      7'h67: begin cls = 3'd5; ie = 1'b1; we = 1'b1; imm = i_imm; ok = (f3 == 3'd0); end
      7'h37: begin cls = 3'd6; ie = 1'b1; we = 1'b1; imm = u_imm; rs1 = 5'd0; end
      7'h17: begin cls = 3'd7; ie = 1'b1; we = 1'b1; imm = u_imm; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      ctrl = '0; imm = '0; ie = 1'b0; we = 1'b0; cls = 3'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ill = 1'b1;
`else
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; f3 = 3'd0;
`endif
    end
    if (rd == 5'd0) we = 1'b0;
    return {pc, ctrl, imm, ie, rs1, rs2, rd, we, cls, f3, ill};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {out_pc, out_ctrl, out_imm, out_imm_en, out_rs1, out_rs2, out_rd,
            out_rd_we, out_class, out_funct3, out_illegal};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Driver: inputs change on the falling edge; an accepted beat pushes its expected decode.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic r, input logic f);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = r; flush = f;
    #2;
    if (v && in_ready && !f && !rst) exp_q.push_back(model(inst, pc));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] inst;
    logic [6:0]  opcs[9];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    inst = $urandom;
    if ($urandom_range(0, 9) != 0) inst[6:0] = opcs[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: inst[31:25] = 7'h00;
      1: inst[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) inst[11:7] = 5'd0;
    return inst;
  endfunction

  // Monitor: checks handshake against the queue occupancy and compares held/consumed beats.
  initial begin
    logic exp_valid;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        exp_valid = (exp_q.size() != 0);
        check("out_valid", W'(out_valid), W'(exp_valid));
        check("in_ready", W'(in_ready), W'(!exp_valid || out_ready));
        if (exp_valid && out_valid) begin
          if (flush) void'(exp_q.pop_front());
          else if (out_ready) check("decode", dut_out(), exp_q.pop_front());
          else check("held", dut_out(), exp_q[0]);
        end else if (exp_valid && flush) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", dut_out(), {RESET_PC, 66'd0});
    check("reset_valid", W'(out_valid), W'(0));
    #1;
    mon_en = 1'b1;

    drive(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b1, 1'b0);
    drive(1'b1, 32'h4020_8133, 32'h0000_0104, 1'b1, 1'b0);
    drive(1'b1, 32'h4030_d193, 32'h0000_0108, 1'b1, 1'b0);
    drive(1'b1, 32'hfff0_a213, 32'h0000_010c, 1'b1, 1'b0);
    drive(1'b1, 32'hfe20_8ee3, 32'h0000_0110, 1'b1, 1'b0);
    drive(1'b1, 32'hffff_ffff, 32'h0000_0114, 1'b1, 1'b0);
    drive(1'b1, 32'h0050_0093, 32'h0000_0118, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 32'h4020_8133, 32'h0000_011c, 1'b0, 1'b0);
    drive(1'b1, 32'h4020_8133, 32'h0000_011c, 1'b1, 1'b0);
    drive(1'b1, 32'h4030_d193, 32'h0000_0120, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (4) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I instruction decode stage; sits between fetch and the integer ALU.
- Converts a 32-bit instruction word into the ALU control interface (ctrl, imm, imm_en) plus register addresses and an op class.
- One-deep pipeline register with valid/ready handshake on both sides and a synchronous flush.

Parameters:
- XLEN, 32, datapath width of pc/imm outputs; only 32 supported.
- RESET_PC, 32'h0000_0000, reset value of out_pc.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drops held instruction (branch redirect)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  pc of in_inst
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute consumes this cycle
- out_pc  out  XLEN  registered pc
- out_ctrl  out  10  ALU ctrl = {funct7[6:0], funct3[2:0]}
- out_imm  out  XLEN  sign-extended immediate
- out_imm_en  out  1  ALU operand B is out_imm
- out_rs1, out_rs2, out_rd  out  5 each  register addresses
- out_rd_we  out  1  register write enable
- out_class  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR, 6 LUI, 7 AUIPC
- out_funct3  out  3  raw funct3 (load width / branch condition)
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset: out_valid=0, out_pc=RESET_PC, all other outputs 0.
- in_ready = !out_valid || out_ready (combinational). Transfer when in_valid && in_ready; outputs update next edge, latency 1 cycle.
- out_valid next = (in_valid && in_ready) ? 1 : (out_ready ? 0 : out_valid). Full throughput, back-to-back.
- Held outputs are stable while out_valid && !out_ready.
- flush: out_valid<=0 next edge, same-cycle input discarded; flush beats transfer. rst beats flush.
- Immediates: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; sign-extended from inst[31].
- OP (0110011): ctrl={funct7,funct3}, imm_en=0, rd_we=1. Legal funct7: 0000000 (any funct3), 0100000 (funct3 000/101 only).
- OP-IMM (0010011): imm_en=1, rd_we=1. funct3 001/101: ctrl={inst[31:25],funct3}, imm=shamt zero-extended; funct7 must be 0000000 (or 0100000 for 101). Other funct3: ctrl={7'b0,funct3} (funct7 zeroed so SLTI/ANDI/etc. select correctly).
- LOAD/STORE: ctrl=0 (ADD), imm_en=1; LOAD rd_we=1, STORE rd_we=0, rs2 valid.
- BRANCH: imm_en=0, imm=B-imm; BEQ/BNE ctrl=0100000000, BLT/BGE 0000000010, BLTU/BGEU 0000000011; funct3 010/011 illegal.
- JAL: ctrl=0, imm=J-imm, rd_we=1. JALR: ctrl=0, imm_en=1, I-imm, rd_we=1.
- LUI: rs1 forced 0, ctrl=0, imm_en=1. AUIPC: ctrl=0, imm_en=1 (execute substitutes pc).
- rd==0 forces rd_we=0 in all classes. Unused rs fields output raw instruction bits.

Optional Feature:
- DECODE_ILLEGAL_TRAP_EN defined: unrecognised opcode/funct combos set out_illegal=1, rd_we=0, class=ALU, ctrl=0.
- Undefined: out_illegal constant 0; unrecognised encodings decode as NOP (ctrl=0, imm_en=0, rd_we=0, rs1=rs2=rd=0).

Test Plan:
- rst high 2 cycles, then low -> out_valid=0, out_pc=RESET_PC; inst 0x00500093 (addi x1,x0,5) in -> next cycle ctrl=0, imm=5, imm_en=1, rd=1, rd_we=1.
- 0x40208133 (sub x2,x1,x2) -> ctrl=10'b0100000000, imm_en=0; 0x4030d193 (srai x3,x1,3) -> ctrl=10'b0100000101, imm=3.
- 0xfff0a213 (slti x4,x1,-1) -> ctrl=10'b0000000010, imm=0xFFFFFFFF; 0xfe208ee3 (beq) -> class=3, imm=0xFFFFFFFC.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next instruction loads same edge.
- flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, no instruction emitted.
- 0xFFFFFFFF with DECODE_ILLEGAL_TRAP_EN -> out_illegal=1, rd_we=0; without -> NOP, out_illegal=0.
